// File: rtl/uart_cmd_framer_if.sv
// uart_cmd_framer_if: byte-receive and command-delivery signals of the UART command framer.
//   rx_data/rx_rdy/clr_rx_rdy : byte handshake with the UART receiver
//   cmd/data/cmd_rdy/clr_cmd_rdy : validated command handshake with the consumer
//   cksum_err/timeout_err/overrun/err_cnt : error pulses and saturating error count
//   modport slave: the framer; modport master: the receiver/consumer side
interface uart_cmd_framer_if;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        cksum_err;
    logic        timeout_err;
    logic        overrun;
    logic [7:0]  err_cnt;
    modport slave (
        input  rx_data, rx_rdy, clr_cmd_rdy,
        output clr_rx_rdy, cmd, data, cmd_rdy, cksum_err, timeout_err, overrun, err_cnt
    );
    modport master (
        output rx_data, rx_rdy, clr_cmd_rdy,
        input  clr_rx_rdy, cmd, data, cmd_rdy, cksum_err, timeout_err, overrun, err_cnt
    );
endinterface

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: assembles SYNC,CMD,DATA_HI,DATA_LO[,CKSUM] byte frames into a validated command.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_cmd_framer_if.slave (receiver byte handshake, command output, error reporting)
//   Define UART_CMD_CKSUM_EN to add the trailing checksum byte (CMD+HI+LO+CK == 8'hFF mod 256).
module uart_cmd_framer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input logic            clk,
    input logic            rst_n,
    uart_cmd_framer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef UART_CMD_CKSUM_EN
    typedef enum logic [2:0] {IDLE, GET_CMD, GET_HI, GET_LO, GET_CK} state_t;
`else
    typedef enum logic [2:0] {IDLE, GET_CMD, GET_HI, GET_LO} state_t;
`endif

    state_t        state, state_n;
    logic          lockout;
    logic [TW-1:0] tcnt;
    logic [7:0]    sh_cmd, sh_hi, lo_byte;
    logic          accept, commit, ck_fail, to_evt, ovr_evt;

    // one byte per rx_rdy assertion: lockout holds off re-accepting until rx_rdy is seen low
    assign accept  = bus.rx_rdy & ~lockout;
    assign ovr_evt = commit & bus.cmd_rdy & ~bus.clr_cmd_rdy;

`ifdef UART_CMD_CKSUM_EN
    logic [7:0] sh_lo, sum;
    assign lo_byte = sh_lo;
    assign sum     = sh_cmd + sh_hi + sh_lo + bus.rx_data;
`else
    assign lo_byte = bus.rx_data;
`endif

    always_comb begin
        state_n = state;
        commit  = 1'b0;
        ck_fail = 1'b0;
        to_evt  = 1'b0;
        if (accept) begin
            case (state)
                IDLE:    state_n = (bus.rx_data == SYNC_BYTE) ? GET_CMD : IDLE;
                GET_CMD: state_n = GET_HI;
                GET_HI:  state_n = GET_LO;
`ifdef UART_CMD_CKSUM_EN
                GET_LO:  state_n = GET_CK;
                GET_CK: begin
                    state_n = IDLE;
                    commit  = (sum == 8'hFF);
                    ck_fail = (sum != 8'hFF);
                end
`else
                GET_LO: begin
                    state_n = IDLE;
                    commit  = 1'b1;
                end
`endif
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && tcnt == TLAST) begin
            // an accepted byte on the expiry cycle wins, hence the else
            to_evt  = 1'b1;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            lockout         <= 1'b0;
            tcnt            <= '0;
            sh_cmd          <= '0;
            sh_hi           <= '0;
`ifdef UART_CMD_CKSUM_EN
            sh_lo           <= '0;
`endif
            bus.clr_rx_rdy  <= 1'b0;
            bus.cmd         <= '0;
            bus.data        <= '0;
            bus.cmd_rdy     <= 1'b0;
            bus.cksum_err   <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.err_cnt     <= '0;
        end else begin
            state          <= state_n;
            lockout        <= bus.rx_rdy & (lockout | accept);
            bus.clr_rx_rdy <= accept;
            tcnt           <= (state_n == IDLE || accept) ? '0 : tcnt + 1'b1;
            if (accept && state == GET_CMD) sh_cmd <= bus.rx_data;
            if (accept && state == GET_HI)  sh_hi  <= bus.rx_data;
`ifdef UART_CMD_CKSUM_EN
            if (accept && state == GET_LO)  sh_lo  <= bus.rx_data;
`endif
            if (commit) begin
                bus.cmd  <= sh_cmd;
                bus.data <= {sh_hi, lo_byte};
            end
            bus.cmd_rdy     <= commit | (bus.cmd_rdy & ~bus.clr_cmd_rdy);
            bus.overrun     <= ovr_evt;
            bus.cksum_err   <= ck_fail;
            bus.timeout_err <= to_evt;
            if ((ck_fail | to_evt | ovr_evt) && bus.err_cnt != 8'hFF)
                bus.err_cnt <= bus.err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb_uart_cmd_framer: directed frames against a byte-position model of the command framer.
module tb_uart_cmd_framer;
    localparam int TMO = 100;
`ifdef UART_CMD_CKSUM_EN
    localparam int FL = 5;
    localparam int ERR_BASE = 1;
`else
    localparam int FL = 4;
    localparam int ERR_BASE = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int clr_cnt = 0, to_seen = 0, ov_seen = 0, ck_seen = 0;

    uart_cmd_framer_if bus();
    uart_cmd_framer #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // model: a byte is taken on every rising edge of rx_rdy; frame position and gap counted in bytes/cycles
    logic        m_prev, m_rdy, m_clr, m_to, m_ck, m_ov;
    int          m_pos, m_gap;
    logic [7:0]  m_buf [0:4];
    logic [7:0]  m_cmd, m_cnt, m_lo;
    logic [15:0] m_data;
    logic        m_acc, m_fin, m_ok, m_commit, m_ovr, m_cke, m_tmo;

    assign m_acc    = bus.rx_rdy & ~m_prev;
    assign m_fin    = m_acc && m_pos == FL - 1;
    assign m_lo     = (FL == 5) ? m_buf[3] : bus.rx_data;
    assign m_ok     = (FL == 4) || (8'(m_buf[1] + m_buf[2] + m_buf[3] + bus.rx_data) == 8'hFF);
    assign m_commit = m_fin && m_ok;
    assign m_cke    = m_fin && !m_ok;
    assign m_ovr    = m_commit && m_rdy && !bus.clr_cmd_rdy;
    assign m_tmo    = !m_acc && m_pos != 0 && m_gap + 1 == TMO;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev <= 0; m_rdy <= 0; m_clr <= 0; m_to <= 0; m_ck <= 0; m_ov <= 0;
            m_pos <= 0; m_gap <= 0; m_cmd <= 0; m_data <= 0; m_cnt <= 0;
            m_buf <= '{default: 8'h00};
        end else begin
            m_prev <= bus.rx_rdy;
            m_clr  <= m_acc;
            m_to   <= m_tmo;
            m_ck   <= m_cke;
            m_ov   <= m_ovr;
            if (m_acc) begin
                m_gap <= 0;
                if (m_pos == 0) m_pos <= (bus.rx_data == 8'hA5) ? 1 : 0;
                else if (m_fin) m_pos <= 0;
                else begin
                    m_buf[m_pos] <= bus.rx_data;
                    m_pos <= m_pos + 1;
                end
            end else if (m_tmo) begin
                m_pos <= 0;
                m_gap <= 0;
            end else if (m_pos != 0) m_gap <= m_gap + 1;
            if (m_commit) begin
                m_cmd  <= m_buf[1];
                m_data <= {m_buf[2], m_lo};
            end
            m_rdy <= m_commit || (m_rdy && !bus.clr_cmd_rdy);
            if ((m_ovr || m_cke || m_tmo) && m_cnt != 8'hFF) m_cnt <= m_cnt + 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'(m_clr));
        chk("cmd", 32'(bus.cmd), 32'(m_cmd));
        chk("data", 32'(bus.data), 32'(m_data));
        chk("cmd_rdy", 32'(bus.cmd_rdy), 32'(m_rdy));
        chk("cksum_err", 32'(bus.cksum_err), 32'(m_ck));
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_to));
        chk("overrun", 32'(bus.overrun), 32'(m_ov));
        chk("err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
        if (bus.clr_rx_rdy) clr_cnt++;
        if (bus.timeout_err) to_seen++;
        if (bus.overrun) ov_seen++;
        if (bus.cksum_err) ck_seen++;
    end

    task automatic send_byte(input logic [7:0] b, input int extra, input logic clr);
        bit got = 0;
        bus.rx_data = b;
        bus.rx_rdy = 1'b1;
        bus.clr_cmd_rdy = clr;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            bus.clr_cmd_rdy = 1'b0;
            got = bus.clr_rx_rdy;
        end
        if (!got) begin
            errors++;
            $display("FAIL clr_rx_rdy_wait: byte %0h never cleared", b);
        end
        repeat (extra) @(negedge clk);
        bus.rx_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo,
                              input logic [7:0] ck, input logic clr_last);
        send_byte(8'hA5, 0, 1'b0);
        send_byte(c, 0, 1'b0);
        send_byte(hi, 0, 1'b0);
        send_byte(lo, 0, (FL == 4) ? clr_last : 1'b0);
        if (FL == 5) send_byte(ck, 0, clr_last);
    endtask

    task automatic ack();
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c0;
        bus.rx_data = 8'h00;
        bus.rx_rdy = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_rdy", 32'(bus.cmd_rdy), 32'h0);
        chk("reset_err_cnt", 32'(bus.err_cnt), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        c0 = clr_cnt;
        send_frame(8'h05, 8'h12, 8'h34, 8'hB4, 1'b0);
        chk("f1_cmd", 32'(bus.cmd), 32'h05);
        chk("f1_data", 32'(bus.data), 32'h1234);
        chk("f1_cmd_rdy", 32'(bus.cmd_rdy), 32'h1);
        chk("f1_err_cnt", 32'(bus.err_cnt), 32'h0);
        chk("f1_clr_pulses", 32'(clr_cnt - c0), 32'(FL));
        ack();

`ifdef UART_CMD_CKSUM_EN
        send_frame(8'h05, 8'h12, 8'h34, 8'hB5, 1'b0);
        chk("bad_ck_pulses", 32'(ck_seen), 32'h1);
        chk("bad_ck_cmd_rdy", 32'(bus.cmd_rdy), 32'h0);
        chk("bad_ck_data", 32'(bus.data), 32'h1234);
        chk("bad_ck_err_cnt", 32'(bus.err_cnt), 32'h1);
`endif

        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hFF, 0, 1'b0);
        send_frame(8'h01, 8'h00, 8'h02, 8'hFC, 1'b0);
        chk("lead_cmd", 32'(bus.cmd), 32'h01);
        chk("lead_data", 32'(bus.data), 32'h0002);
        chk("lead_err_cnt", 32'(bus.err_cnt), 32'(ERR_BASE));
        ack();

        send_byte(8'hA5, 0, 1'b0);
        send_byte(8'h07, 0, 1'b0);
        repeat (110) @(negedge clk);
        chk("tmo_pulses", 32'(to_seen), 32'h1);
        chk("tmo_cmd_rdy", 32'(bus.cmd_rdy), 32'h0);
        send_frame(8'h07, 8'h00, 8'h09, 8'hEF, 1'b0);
        chk("post_tmo_cmd", 32'(bus.cmd), 32'h07);
        chk("post_tmo_data", 32'(bus.data), 32'h0009);
        ack();

        send_frame(8'h11, 8'hAA, 8'h55, 8'hEF, 1'b0);
        send_frame(8'h22, 8'hBE, 8'hEF, 8'h30, 1'b0);
        chk("ovr_pulses", 32'(ov_seen), 32'h1);
        chk("ovr_data", 32'(bus.data), 32'hBEEF);
        chk("ovr_err_cnt", 32'(bus.err_cnt), 32'(ERR_BASE + 2));
        send_frame(8'h33, 8'h00, 8'h01, 8'hCB, 1'b1);
        chk("setwins_cmd_rdy", 32'(bus.cmd_rdy), 32'h1);
        chk("setwins_no_ovr", 32'(ov_seen), 32'h1);
        chk("setwins_cmd", 32'(bus.cmd), 32'h33);
        ack();

        c0 = clr_cnt;
        send_byte(8'hA5, 3, 1'b0);
        repeat (2) @(negedge clk);
        chk("slow_clr_one_byte", 32'(clr_cnt - c0), 32'h1);
        send_byte(8'h44, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        if (FL == 5) send_byte(8'h75, 0, 1'b0);
        chk("slow_cmd", 32'(bus.cmd), 32'h44);
        chk("slow_data", 32'(bus.data), 32'h1234);

        send_byte(8'hA5, 0, 1'b0);
        send_byte(8'h55, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_cmd", 32'(bus.cmd), 32'h0);
        chk("rst_data", 32'(bus.data), 32'h0);
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'h0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h66, 8'h77, 8'h88, 8'h9A, 1'b0);
        chk("after_rst_cmd", 32'(bus.cmd), 32'h66);
        chk("after_rst_data", 32'(bus.data), 32'h7788);
        chk("after_rst_cmd_rdy", 32'(bus.cmd_rdy), 32'h1);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
